// File: rtl/network_controller.sv
// Sequencing controller for the two-layer digit-recognizer datapath: buffers the
// image, fetches weights/biases from flash, drives the external MAC and fills sigmoid memory.
module network_controller #(
  parameter int N_IN  = 16,
  parameter int N_HID = 16,
  parameter int N_OUT = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        write_en,
  input  logic [7:0]  pixel_data1,
  input  logic [7:0]  pixel_data2,
  input  logic [15:0] flashData_out,
  input  logic [3:0]  sigmoidData_out,
  input  logic [3:0]  ALUOutput,
  output logic        data_ready,
  output logic        shift_network,
  output logic        flash_ready,
  output logic [15:0] flash_address,
  output logic        network_done,
  output logic [3:0]  sigmoidData_in,
  output logic [4:0]  sigmoid_address,
  output logic        sigmoid_write_en,
  output logic [3:0]  weight1,
  output logic [3:0]  weight2,
  output logic [3:0]  weight3,
  output logic [3:0]  weight4,
  output logic [3:0]  bias,
  output logic [3:0]  input1,
  output logic [3:0]  input2,
  output logic [3:0]  input3,
  output logic [3:0]  input4,
  output logic        clear,
  output logic        accumulate
);
  localparam int          GROUPS  = N_IN / 4;
  localparam int          GW      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int          KW      = $clog2(N_IN);
  localparam int          NW      = $clog2(N_HID);
  localparam logic [15:0] STRIDE  = 16'(GROUPS + 1);
  localparam logic [15:0] L2_BASE = 16'((GROUPS + 1) * N_HID);

  typedef enum logic [3:0] {
    IDLE, RECEIVE, CLEAR, FETCH, ACC, FETCH_BIAS, WRITE, COPY, DONE
  } state_t;

  state_t        state, state_next;
  logic [3:0]    buffer [N_IN];
  logic [GW-1:0] beat, group;
  logic [NW-1:0] neuron;
  logic [KW-1:0] copy_idx;
  logic          layer2;
  logic [15:0]   row_base;
  logic          last_beat, last_group, last_neuron, last_copy;

  assign last_beat   = (beat == GW'(GROUPS - 1));
  assign last_group  = (group == GW'(GROUPS - 1));
  assign last_copy   = (copy_idx == KW'(N_IN - 1));
  assign last_neuron = layer2 ? (neuron == NW'(N_OUT - 1)) : (neuron == NW'(N_HID - 1));
  // Each neuron owns GROUPS weight words followed by one bias word.
  assign row_base    = (layer2 ? L2_BASE : 16'd0) + 16'(neuron) * STRIDE;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    data_ready       = 1'b0;
    shift_network    = 1'b0;
    flash_ready      = 1'b0;
    flash_address    = '0;
    network_done     = 1'b0;
    sigmoidData_in   = '0;
    sigmoid_address  = '0;
    sigmoid_write_en = 1'b0;
    weight1          = '0;
    weight2          = '0;
    weight3          = '0;
    weight4          = '0;
    bias             = '0;
    input1           = '0;
    input2           = '0;
    input3           = '0;
    input4           = '0;
    clear            = 1'b0;
    accumulate       = 1'b0;
    unique case (state)
      IDLE, DONE, RECEIVE: begin
        data_ready   = 1'b1;
        network_done = (state == DONE);
        if (write_en) begin
          shift_network = 1'b1;
          state_next    = last_beat ? CLEAR : RECEIVE;
        end
      end
      CLEAR: begin
        clear      = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        flash_ready   = 1'b1;
        flash_address = row_base + 16'(group);
        state_next    = ACC;
      end
      ACC: begin
        weight1    = flashData_out[15:12];
        weight2    = flashData_out[11:8];
        weight3    = flashData_out[7:4];
        weight4    = flashData_out[3:0];
        input1     = buffer[{group, 2'd0}];
        input2     = buffer[{group, 2'd1}];
        input3     = buffer[{group, 2'd2}];
        input4     = buffer[{group, 2'd3}];
        accumulate = 1'b1;
        state_next = last_group ? FETCH_BIAS : FETCH;
      end
      FETCH_BIAS: begin
        flash_ready   = 1'b1;
        flash_address = row_base + STRIDE - 16'd1;
        state_next    = WRITE;
      end
      WRITE: begin
        bias             = flashData_out[3:0];
        sigmoid_write_en = 1'b1;
        sigmoidData_in   = ALUOutput;
        sigmoid_address  = layer2 ? 5'(N_HID) + 5'(neuron) : 5'(neuron);
        if (!last_neuron) state_next = CLEAR;
        else              state_next = layer2 ? DONE : COPY;
      end
      COPY: begin
        sigmoid_address = 5'(copy_idx);
        if (last_copy) state_next = CLEAR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      buffer   <= '{default: '0};
      beat     <= '0;
      group    <= '0;
      neuron   <= '0;
      copy_idx <= '0;
      layer2   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, RECEIVE: begin
          if (write_en) begin
            buffer[{beat, 2'd0}] <= pixel_data1[7:4];
            buffer[{beat, 2'd1}] <= pixel_data1[3:0];
            buffer[{beat, 2'd2}] <= pixel_data2[7:4];
            buffer[{beat, 2'd3}] <= pixel_data2[3:0];
            beat <= last_beat ? '0 : beat + GW'(1);
            if (last_beat) begin
              layer2 <= 1'b0;
              neuron <= '0;
            end
          end
        end
        CLEAR: group <= '0;
        ACC: if (!last_group) group <= group + GW'(1);
        WRITE: begin
          if (last_neuron) begin
            neuron   <= '0;
            copy_idx <= '0;
          end else begin
            neuron <= neuron + NW'(1);
          end
        end
        // Hidden activations become the layer-2 input vector.
        COPY: begin
          buffer[copy_idx] <= sigmoidData_out;
          copy_idx         <= copy_idx + KW'(1);
          if (last_copy) begin
            layer2 <= 1'b1;
            neuron <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_network_controller.sv
// Scoreboard bench for network_controller: models flash, sigmoid memory and the ALU output.
module tb_network_controller;
  logic        clk = 1'b0;
  logic        n_rst, write_en;
  logic [7:0]  pixel_data1, pixel_data2;
  logic [15:0] flashData_out;
  logic [3:0]  sigmoidData_out, ALUOutput;
  logic        data_ready, shift_network, flash_ready, network_done;
  logic [15:0] flash_address;
  logic [3:0]  sigmoidData_in, bias;
  logic [4:0]  sigmoid_address;
  logic        sigmoid_write_en, clear, accumulate;
  logic [3:0]  weight1, weight2, weight3, weight4, input1, input2, input3, input4;

  network_controller #(.N_IN(16), .N_HID(16), .N_OUT(10)) dut (
    .clk(clk), .n_rst(n_rst), .write_en(write_en),
    .pixel_data1(pixel_data1), .pixel_data2(pixel_data2),
    .flashData_out(flashData_out), .sigmoidData_out(sigmoidData_out), .ALUOutput(ALUOutput),
    .data_ready(data_ready), .shift_network(shift_network), .flash_ready(flash_ready),
    .flash_address(flash_address), .network_done(network_done),
    .sigmoidData_in(sigmoidData_in), .sigmoid_address(sigmoid_address),
    .sigmoid_write_en(sigmoid_write_en),
    .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4), .bias(bias),
    .input1(input1), .input2(input2), .input3(input3), .input4(input4),
    .clear(clear), .accumulate(accumulate)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] smem [32];
  logic [3:0] img [16];
  logic alu_mode = 1'b0;
  logic [15:0] q_fa [$];
  logic [31:0] q_acc [$];
  logic [12:0] q_wr [$];
  int shift_count = 0, wr_count = 0, cyc = 0, last_clear = 0, grp = 0;

  function automatic logic [15:0] flash_word(input logic [15:0] a);
    if (a == 16'd0) return 16'hABCD;
    return {a[3:0], a[7:4], ~a[3:0], a[3:0] ^ 4'h5};
  endfunction

  // Flash returns data the cycle after the request; sigmoid memory reads combinationally.
  initial flashData_out = '0;
  always @(posedge clk) if (flash_ready) flashData_out <= flash_word(flash_address);
  always @(posedge clk) if (sigmoid_write_en) smem[sigmoid_address] <= sigmoidData_in;
  assign sigmoidData_out = smem[sigmoid_address];
  assign ALUOutput = alu_mode ? sigmoid_address[3:0] + 4'd1 : 4'h7;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=none (queue empty)", name);
  endtask

  // Expected transaction stream for one image; mode selects the ALU output model.
  task automatic push_expected(input logic mode);
    logic [3:0] b [16];
    logic [15:0] a, wrd;
    logic [3:0] v;
    int base, nmax, abase;
    for (int i = 0; i < 16; i++) b[i] = img[i];
    for (int layer = 1; layer <= 2; layer++) begin
      base  = (layer == 1) ? 0 : 80;
      abase = (layer == 1) ? 0 : 16;
      nmax  = (layer == 1) ? 16 : 10;
      for (int n = 0; n < nmax; n++) begin
        for (int g = 0; g < 4; g++) begin
          a = 16'(base + n * 5 + g);
          q_fa.push_back(a);
          q_acc.push_back({flash_word(a), b[4*g], b[4*g+1], b[4*g+2], b[4*g+3]});
        end
        a = 16'(base + n * 5 + 4);
        q_fa.push_back(a);
        wrd = flash_word(a);
        v = mode ? 4'(n + 1) : 4'h7;
        q_wr.push_back({5'(abase + n), v, wrd[3:0]});
      end
      for (int k = 0; k < 16; k++) b[k] = mode ? 4'(k + 1) : 4'h7;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (n_rst === 1'b0) begin
      if (shift_network) shift_count++;
      if (clear) begin last_clear = cyc; grp = 0; end
      if (flash_ready) begin
        if (q_fa.size() == 0) unexpected("flash_req");
        else check("flash_address", flash_address, q_fa.pop_front());
      end
      if (accumulate) begin
        if (grp == 0) check("clear_to_acc", cyc - last_clear, 2);
        grp++;
        if (q_acc.size() == 0) unexpected("acc");
        else check("acc_w_in", {weight1, weight2, weight3, weight4, input1, input2, input3, input4},
                   q_acc.pop_front());
      end else begin
        check("idle_operands", {weight1, weight2, weight3, weight4, input1, input2, input3, input4}, 0);
      end
      if (sigmoid_write_en) begin
        wr_count++;
        if (q_wr.size() == 0) unexpected("sigmoid_write");
        else check("sigmoid_write", {sigmoid_address, sigmoidData_in, bias}, q_wr.pop_front());
      end else begin
        check("idle_bias", bias, 0);
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, data_ready, 1);
    check({name, "_zero"}, {shift_network, flash_ready, flash_address, network_done, sigmoidData_in,
          sigmoid_address, sigmoid_write_en, weight1, weight2, weight3, weight4, bias,
          input1, input2, input3, input4, clear, accumulate}, 0);
  endtask

  task automatic send_beat(input logic [7:0] p1, input logic [7:0] p2);
    write_en = 1'b1; pixel_data1 = p1; pixel_data2 = p2;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic wait_done(input bit intrude, output int n);
    n = 0;
    while (network_done !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
      write_en = 1'b0;
      if (intrude && n == 50) begin
        check("busy_data_ready", data_ready, 0);
        write_en = 1'b1; pixel_data1 = 8'hFF; pixel_data2 = 8'hFF;
      end
    end
    write_en = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, {16'(q_fa.size()), 16'(q_acc.size()), 16'(q_wr.size())}, 0);
  endtask

  initial begin
    int lat, s0, w0;
    n_rst = 1'b1; write_en = 1'b0; pixel_data1 = '0; pixel_data2 = '0;
    for (int i = 0; i < 32; i++) smem[i] = '0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    n_rst = 1'b0;
    @(posedge clk); #1;

    // Image A: 1,2,3,4 repeated, ALU output fixed at 7, one stray write_en mid-compute
    for (int i = 0; i < 16; i++) img[i] = 4'((i % 4) + 1);
    alu_mode = 1'b0;
    push_expected(1'b0);
    s0 = shift_count;
    for (int b = 0; b < 4; b++) begin
      check("ready_before_beat", data_ready, 1);
      send_beat(8'h12, 8'h34);
    end
    check("ready_after_last_beat", data_ready, 0);
    check("shift_pulses_a", shift_count - s0, 4);
    wait_done(1'b1, lat);
    check("latency_a", lat, 302);
    check_drained("drained_a");
    check("shift_ignored_busy", shift_count - s0, 4);
    repeat (5) @(posedge clk); #1;
    check("done_hold", {network_done, data_ready}, 2'b11);

    // Image B: pixel i = i, ALU output = address+1 so COPY contents are distinguishable
    for (int i = 0; i < 16; i++) img[i] = 4'(i);
    alu_mode = 1'b1;
    push_expected(1'b1);
    s0 = shift_count;
    for (int b = 0; b < 4; b++) begin
      send_beat({4'(4*b), 4'(4*b+1)}, {4'(4*b+2), 4'(4*b+3)});
      if (b == 0) check("done_cleared", network_done, 0);
    end
    check("shift_pulses_b", shift_count - s0, 4);
    wait_done(1'b0, lat);
    check("latency_b", lat, 302);
    check_drained("drained_b");

    // Image C: reset in the middle of layer 1
    for (int i = 0; i < 16; i++) img[i] = 4'((i % 4) + 1);
    alu_mode = 1'b0;
    push_expected(1'b0);
    for (int b = 0; b < 4; b++) send_beat(8'h12, 8'h34);
    repeat (40) @(posedge clk); #1;
    n_rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    q_fa.delete(); q_acc.delete(); q_wr.delete();
    w0 = wr_count;
    repeat (3) @(posedge clk); #1;
    n_rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("no_write_after_reset", wr_count - w0, 0);
    check_reset_outputs("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/network_controller.md
Name: network_controller

Overview:
Sequencing controller for the digit-recognizer datapath. It buffers a 16-pixel input image and fetches packed weights and biases from flash. It drives an external multiply-accumulate ALU four products at a time and writes activated neuron outputs to a 32-entry sigmoid memory. The network has two layers: 16 inputs -> 16 hidden neurons -> 10 outputs.

Parameters:
N_IN, 16, pixels per image; must be a multiple of 4.
N_HID, 16, hidden neurons; N_HID must equal N_IN.
N_OUT, 10, output neurons; N_HID + N_OUT <= 32.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous reset, active-high despite the codebase name
write_en  in  1  image beat valid
pixel_data1  in  8  pixels 0/1 of beat, [7:4] then [3:0]
pixel_data2  in  8  pixels 2/3 of beat, [7:4] then [3:0]
flashData_out  in  16  flash read data, valid the cycle after the request
sigmoidData_out  in  4  sigmoid memory combinational read data
ALUOutput  in  4  activated ALU result: sigmoid(accumulator + bias)
data_ready  out  1  controller can accept an image
shift_network  out  1  one-cycle pulse per accepted beat
flash_ready  out  1  flash read request
flash_address  out  16  flash word address
network_done  out  1  all outputs written
sigmoidData_in  out  4  sigmoid memory write data
sigmoid_address  out  5  sigmoid memory address
sigmoid_write_en  out  1  sigmoid memory write strobe
weight1..weight4  out  4 each  ALU weights
bias  out  4  ALU bias
input1..input4  out  4 each  ALU operands
clear  out  1  zero the ALU accumulator
accumulate  out  1  ALU adds sum(weight_k*input_k) at this edge

Behaviour:
- Reset: state IDLE; data_ready=1; all other outputs 0; input buffer, beat, group and neuron counters cleared. Reset mid-operation aborts immediately with no further writes.
- Input buffer: 16x4-bit. Beat b stores pixel_data1[7:4], pixel_data1[3:0], pixel_data2[7:4], pixel_data2[3:0] into buffer[4b..4b+3].
- IDLE/DONE: data_ready=1. A write_en stores beat 0, pulses shift_network, and moves to RECEIVE. DONE holds network_done=1 until that write_en.
- RECEIVE: data_ready=1. Each write_en stores the next beat and pulses shift_network. After beat N_IN/4-1: data_ready=0, layer=1, neuron=0, go to CLEAR. Cycles without write_en hold state.
- write_en is ignored in every computing state.
- CLEAR: clear=1 for 1 cycle; group g=0.
- FETCH: flash_ready=1, flash_address = layer_base + neuron*5 + g.
- ACC: weight1..4 = flashData_out[15:12], [11:8], [7:4], [3:0] (combinational). input1..4 = buffer[4g..4g+3]. accumulate=1. If g<3: g++ and go to FETCH, else go to FETCH_BIAS.
- FETCH_BIAS: flash_ready=1, flash_address = layer_base + neuron*5 + 4.
- WRITE: bias = flashData_out[3:0]; sigmoid_write_en=1; sigmoidData_in = ALUOutput; sigmoid_address = neuron (layer 1) or 16+neuron (layer 2).
- After WRITE: next neuron goes to CLEAR. Layer-1 end goes to COPY. Layer-2 end goes to DONE and sets network_done=1.
- layer_base: 0 for layer 1, 5*N_HID=80 for layer 2.
- COPY: 16 cycles; sigmoid_address = k for k=0..15; buffer[k] <= sigmoidData_out; sigmoid_write_en=0. Then layer=2, neuron=0, go to CLEAR.
- Per-neuron cost is 11 cycles. Full image after the last beat: 16*11 + 16 + 10*11 = 302 cycles to network_done.
- Outputs not named for a state are 0 in that state, except data_ready and network_done as stated above.
- flash_address bits beyond 8 are 0.
- weight*, bias and input* outputs are 0 when not in ACC/WRITE.

Test Plan:
- Reset asserted mid-compute -> all outputs 0 except data_ready=1; no sigmoid_write_en afterward.
- 4 beats of pixel_data1=8'h12, pixel_data2=8'h34 -> shift_network pulses 4x; data_ready falls after beat 4. First ACC shows input1..4=1,2,3,4 and clear precedes it by 2 cycles.
- Flash model returning 16'hABCD at address 0 -> first ACC cycle weight1..4=A,B,C,D. flash_address sequence is 0,1,2,3,4 for neuron 0 and 5..9 for neuron 1.
- ALUOutput tied to 4'h7 -> 16 writes at addresses 0..15, COPY reads 0..15, then 10 writes at 16..25 with data 7. Layer-2 first fetch address is 80.
- Count cycles from last beat to network_done -> exactly 302. network_done stays 1 until the next write_en, then clears.
- write_en pulsed during compute -> ignored: buffer unchanged, no shift_network pulse.
